// File: rtl/mcyc_stall_ctrl.sv
// Pipeline stall merge plus MAC/divide sequencing for the 5-stage core.
// Optional divider watchdog is built when DIV_TIMEOUT_EN is defined.
module mcyc_stall_ctrl #(
    parameter int DIV_MAX_CYC = 40,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stallreq_i,
    input  logic             mem_stallreq_i,
    input  logic             ex_mac_i,
    input  logic             ex_div_i,
    input  logic             div_ready_i,
    input  logic             flush_i,
    output logic [5:0]       stall_o,
    output logic             mac_phase_o,
    output logic             div_start_o,
    output logic             div_annul_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             div_timeout_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC2 = 2'd1;
    localparam logic [1:0] DIVW = 2'd2;

    if (DIV_MAX_CYC < 1) begin : g_bad_param
        $error("DIV_MAX_CYC must be at least 1");
    end

    logic [1:0] state, state_nxt;
    logic       ex_stallreq;
    logic       wd_hit;

    always_comb begin
        ex_stallreq = 1'b0;
        case (state)
            IDLE:    ex_stallreq = ex_mac_i | ex_div_i;
            MAC2:    ex_stallreq = 1'b0;
            DIVW:    ex_stallreq = !div_ready_i;
            default: ex_stallreq = 1'b0;
        endcase
    end

    // Flush releases everything; otherwise the deepest requester wins.
    always_comb begin
        stall_o = 6'b000000;
        if (rst || flush_i)       stall_o = 6'b000000;
        else if (mem_stallreq_i)  stall_o = 6'b011111;
        else if (ex_stallreq)     stall_o = 6'b001111;
        else if (id_stallreq_i)   stall_o = 6'b000111;
    end

`ifdef DIV_TIMEOUT_EN
    localparam int WD_W = $clog2(DIV_MAX_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_MAX_CYC - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_hit        = (state == DIVW) && !div_ready_i && (wd_cnt == WD_LAST);
    assign div_timeout_o = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != DIVW)    wd_cnt <= '0;
            else if (!div_ready_i) wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit)            timeout_q <= 1'b1;
        end
    end
`else
    assign wd_hit        = 1'b0;
    assign div_timeout_o = 1'b0;
`endif

    // In MAC2 stall_o[3] can only come from MEM; in DIVW it also covers !ready.
    always_comb begin
        state_nxt = state;
        if (flush_i || wd_hit) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_i)      state_nxt = DIVW;
                    else if (ex_mac_i) state_nxt = MAC2;
                end
                MAC2:    if (!stall_o[3]) state_nxt = IDLE;
                DIVW:    if (div_ready_i && !stall_o[3]) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign mac_phase_o = !rst && (state == MAC2) && !flush_i;
    assign div_start_o = !rst && (state == DIVW);
    assign div_annul_o = !rst && (state == DIVW) && (flush_i || wd_hit);
    assign busy_o      = !rst && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_o <= '0;
        else if ((stall_o != 6'b000000) && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_mcyc_stall_ctrl.sv
// Directed + random bench for mcyc_stall_ctrl against a transaction-level model.
// Watchdog expectations follow DIV_TIMEOUT_EN when defined.
module tb_mcyc_stall_ctrl;

    localparam int CW  = 8;
    localparam int DMC = 40;

    logic          clk = 1'b0;
    logic          rst, id_req, mem_req, ex_mac, ex_div, div_ready, flush;
    logic [5:0]    stall_o;
    logic          mac_phase_o, div_start_o, div_annul_o, busy_o, div_timeout_o;
    logic [CW-1:0] stall_cnt_o;

    int compared = 0;
    int mism     = 0;

    // Model: which multi-cycle op is outstanding (0 none, 1 MAC accumulate, 2 divide wait)
    int m_op, m_cnt, m_wd;
    bit m_to;
    int ds_hi, ann_hi;

    mcyc_stall_ctrl #(.DIV_MAX_CYC(DMC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_stallreq_i(id_req), .mem_stallreq_i(mem_req),
        .ex_mac_i(ex_mac), .ex_div_i(ex_div), .div_ready_i(div_ready), .flush_i(flush),
        .stall_o(stall_o), .mac_phase_o(mac_phase_o), .div_start_o(div_start_o),
        .div_annul_o(div_annul_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o),
        .div_timeout_o(div_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational/registered outputs mid-cycle, then advance the model.
    task automatic cyc();
        int depth;
        bit exreq, hit;
        logic [5:0] e_st;
        @(negedge clk);
        hit = 1'b0;
`ifdef DIV_TIMEOUT_EN
        hit = (m_op == 2) && !div_ready && (m_wd == DMC - 1);
`endif
        exreq = (m_op == 0) ? (ex_mac | ex_div) : (m_op == 1) ? 1'b0 : !div_ready;
        depth = (rst || flush) ? 0 : mem_req ? 5 : exreq ? 4 : id_req ? 3 : 0;
        e_st  = 6'((1 << depth) - 1);
        chk("stall",     32'(stall_o),     32'(e_st));
        chk("mac_phase", 32'(mac_phase_o), 32'(!rst && m_op == 1 && !flush));
        chk("div_start", 32'(div_start_o), 32'(!rst && m_op == 2));
        chk("div_annul", 32'(div_annul_o), 32'(!rst && m_op == 2 && (flush || hit)));
        chk("busy",      32'(busy_o),      32'(!rst && m_op != 0));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        chk("timeout",   32'(div_timeout_o), 32'(m_to));
        if (div_start_o === 1'b1) ds_hi++;
        if (div_annul_o === 1'b1) ann_hi++;
        @(posedge clk);
        if (rst) begin
            m_op = 0; m_cnt = 0; m_to = 1'b0; m_wd = 0;
        end else begin
            if (e_st != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (hit) m_to = 1'b1;
            if (flush || hit) m_op = 0;
            else if (m_op == 0) begin
                if (ex_div)      begin m_op = 2; m_wd = 0; end
                else if (ex_mac) m_op = 1;
            end else if (m_op == 1) begin
                if (!mem_req) m_op = 0;
            end else begin
                if (div_ready && !mem_req) m_op = 0;
                else if (!div_ready)       m_wd++;
            end
        end
        #1;
    endtask

    task automatic idle_in();
        id_req = 0; mem_req = 0; ex_mac = 0; ex_div = 0; div_ready = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst = 1; cyc(); rst = 0;
    endtask

    initial begin
        m_op = 0; m_cnt = 0; m_to = 0; m_wd = 0; ds_hi = 0; ann_hi = 0;
        idle_in();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        cyc();
        chk("rst_cnt",  32'(stall_cnt_o), 0);
        chk("rst_busy", 32'(busy_o), 0);

        // MAC without stalls: one bubble then accumulate phase
        ex_mac = 1; cyc(); cyc();
        ex_mac = 0; cyc();

        // Divide with ready after 34 wait cycles
        do_reset();
        ds_hi = 0;
        ex_div = 1; cyc();
        repeat (34) cyc();
        div_ready = 1; cyc();
        ex_div = 0; div_ready = 0; cyc();
        chk("div_start_cycles", 32'(ds_hi), 35);
        chk("div_stall_cnt",    32'(stall_cnt_o), 35);

        // Flush at DIVW cycle 10
        ann_hi = 0;
        ex_div = 1; cyc();
        repeat (9) cyc();
        flush = 1; cyc();
        flush = 0; ex_div = 0; cyc();
        chk("flush_annul_cycles", 32'(ann_hi), 1);
        chk("flush_idle",         32'(busy_o), 0);

        // MAC2 held by MEM stall with ID request masked
        ex_mac = 1; cyc();
        mem_req = 1; id_req = 1;
        repeat (3) cyc();
        idle_in(); cyc(); cyc();

        // Both op flags: divide wins; then flush against a new op in IDLE
        ex_mac = 1; ex_div = 1; cyc();
        ex_mac = 0; div_ready = 1; cyc();
        idle_in(); flush = 1; ex_div = 1; ex_mac = 1; cyc();
        idle_in(); cyc();

        // Reset while dividing: no annul
        ex_div = 1; cyc(); cyc();
        rst = 1; cyc(); rst = 0; idle_in(); cyc();

        // Divider never ready for 100 cycles
        ann_hi = 0;
        ex_div = 1;
        repeat (100) cyc();
`ifdef DIV_TIMEOUT_EN
        chk("wd_sticky", 32'(div_timeout_o), 1);
        chk("wd_pulses", 32'(ann_hi), 2);
`else
        chk("hang_stall", 32'(stall_o), 32'h0f);
        chk("hang_no_to", 32'(div_timeout_o), 0);
`endif
        idle_in(); flush = 1; cyc();
        idle_in(); cyc();

        // Counter saturation
        do_reset();
        id_req = 1;
        repeat (300) cyc();
        id_req = 0; cyc();
        chk("cnt_sat", 32'(stall_cnt_o), 32'((1 << CW) - 1));

        // Randomized traffic
        do_reset();
        repeat (2000) begin
            rst       = ($urandom_range(63) == 0);
            flush     = ($urandom_range(15) == 0);
            mem_req   = ($urandom_range(3) == 0);
            id_req    = ($urandom_range(3) == 0);
            ex_mac    = ($urandom_range(3) == 0);
            ex_div    = ($urandom_range(7) == 0);
            div_ready = ($urandom_range(3) == 0);
            cyc();
        end
        rst = 0; idle_in(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/mcyc_stall_ctrl.md
Name: mcyc_stall_ctrl

Overview:
Pipeline stall controller and multi-cycle operation sequencer for the 5-stage core.
- Merges stall requests from ID and MEM with its own EX-stage requests into the per-stage stall vector that drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences the 2-cycle MADD/MADDU/MSUB/MSUBU accumulate.
- Drives start/annul handshakes to the iterative divider.
- Sits beside the pipeline registers; EX decodes its op class and sends flags here.

Parameters:
DIV_MAX_CYC, 40, divider watchdog limit in cycles (used only with the optional feature)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  reset
id_stallreq_i  in  1  ID stage requests stall
mem_stallreq_i  in  1  MEM stage requests stall
ex_mac_i  in  1  EX holds MADD/MADDU/MSUB/MSUBU
ex_div_i  in  1  EX holds DIV/DIVU
div_ready_i  in  1  divider result valid (level, held until div_start_o drops)
flush_i  in  1  pipeline flush (exception/branch cancel)
stall_o  out  6  [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB hold
mac_phase_o  out  1  0 = first MAC cycle (compute product), 1 = second cycle (accumulate into HI/LO)
div_start_o  out  1  divider run request
div_annul_o  out  1  one-cycle divider cancel
busy_o  out  1  FSM not in IDLE
stall_cnt_o  out  CNT_W  cycles with stall_o != 0, saturating
div_timeout_o  out  1  watchdog fired (sticky until rst; optional feature only)

Behaviour:
- Reset is rst: synchronous, active-high. On reset:
  - state = IDLE
  - stall_o = 0, mac_phase_o = 0, div_start_o = 0, div_annul_o = 0, busy_o = 0
  - stall_cnt_o = 0, div_timeout_o = 0
  - Reset mid-operation abandons any MAC or divide without asserting div_annul_o.
- FSM states: IDLE, MAC2, DIVW.
- ex_stallreq (internal, combinational):
  - IDLE: ex_mac_i | ex_div_i
  - MAC2: 0
  - DIVW: !div_ready_i
- stall_o (combinational) priority:
  - flush_i -> 6'b000000
  - mem_stallreq_i -> 6'b011111
  - ex_stallreq -> 6'b001111
  - id_stallreq_i -> 6'b000111
  - otherwise 6'b000000
- IDLE transitions:
  - ex_mac_i & !flush_i -> MAC2. mac_phase_o = 0 this cycle.
  - ex_div_i & !flush_i -> DIVW. div_start_o = 0 this cycle; it rises in the first DIVW cycle.
  - If ex_mac_i and ex_div_i are both high, div has priority. This is a decode error, but behaviour is defined.
- MAC2:
  - mac_phase_o = 1.
  - If stall_o[3] is set (MEM stall holds EX), remain in MAC2.
  - Otherwise -> IDLE.
- DIVW:
  - div_start_o = 1.
  - When div_ready_i = 1: EX stall drops the same cycle.
    - If stall_o[3] is set, remain in DIVW with div_start_o still high, so the result stays held.
    - Otherwise -> IDLE, and div_start_o = 0 next cycle.
- flush_i (any state):
  - Next state = IDLE.
  - div_annul_o = 1 in that cycle only if state == DIVW.
  - mac_phase_o forced 0 in that cycle.
  - Flush wins over a simultaneous ex_mac_i or ex_div_i.
- busy_o = (state != IDLE), combinational from the state register.
- stall_cnt_o increments by 1 on each clock where stall_o != 0 and saturates at all-ones.
- MAC latency: 2 EX cycles, with exactly 1 inserted bubble when there is no MEM stall.
- Divide latency: divider latency + 1 cycle.

Optional Feature:
Macro DIV_TIMEOUT_EN.
- Defined:
  - A counter clears on DIVW entry and increments each DIVW cycle with !div_ready_i.
  - When it reaches DIV_MAX_CYC: next state = IDLE, div_annul_o pulses 1 cycle, div_timeout_o sets (sticky).
  - The stall is released the cycle after the pulse.
- Undefined:
  - No counter is built.
  - div_timeout_o tied 0.
  - DIVW waits indefinitely for div_ready_i.

Test Plan:
- Reset with all inputs 0 -> stall_o = 0, busy_o = 0, stall_cnt_o = 0 on the next clk.
- ex_mac_i = 1 for 2 cycles, no other stalls -> cycle 0: stall_o = 6'b001111, mac_phase_o = 0; cycle 1: stall_o = 0, mac_phase_o = 1; cycle 2: busy_o = 0.
- ex_div_i = 1, div_ready_i rises after 34 cycles -> div_start_o high for 35 cycles; stall_o = 6'b001111 until the ready cycle, then 0; stall_cnt_o = 35.
- In DIVW, assert flush_i at cycle 10 -> div_annul_o = 1 for 1 cycle, stall_o = 0, state IDLE next cycle, div_start_o = 0.
- In MAC2 with mem_stallreq_i = 1 for 3 cycles -> stall_o = 6'b011111, mac_phase_o stays 1 for 3 cycles, then leaves to IDLE; simultaneous id_stallreq_i is masked.
- With DIV_TIMEOUT_EN, DIV_MAX_CYC = 40, div_ready_i held 0 -> div_annul_o pulses at DIVW cycle 40, div_timeout_o = 1 and stays 1; without the macro, stall persists at cycle 100.
